// File: rtl/bram_bridge_pkg.sv
// Shared types and constants for the BRAM bus bridge and the memory models
// that sit next to it.
package bram_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle,
    StRdata,
    StResp
  } state_e;

  // Canonical no-op instruction; memory models fill unwritten space with it.
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/bram_load_align.sv
// Load lane extraction and sign/zero extension. Also used by the fetch path.
module bram_load_align
  import bram_bridge_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [15:0] shifted;
  logic        sign;

  always_comb begin
    shifted  = 16'(rdata_i >> {offset_i, 3'b000});
    sign     = 1'b0;
    result_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        sign     = ~unsigned_i & shifted[7];
        result_o = {{24{sign}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sign     = ~unsigned_i & shifted[15];
        result_o = {{16{sign}}, shifted[15:0]};
      end
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/bram_bus_bridge.sv
// Single-outstanding load/store bridge onto a registered-read block RAM port.
// Define BRAM_BRIDGE_ACCESS_FAULT_EN to report misaligned/out-of-window accesses via rsp_err.
module bram_bus_bridge
  import bram_bridge_pkg::*;
#(
  parameter int unsigned AW = 14,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (DW != 32) begin : g_dw_check
    $error("bram_bus_bridge: only DW=32 is supported");
  end

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  size_e       req_sz;
  size_e       sz_n;
  logic [1:0]  off_n;
  logic        fault;
  logic        accept;
  logic        mem_go;
  logic [31:0] align_res;

  assign req_ready = (state_q == StIdle);
  // Gate with rst_n so no RAM cycle leaks out while reset is held.
  assign accept    = req_valid & req_ready & rst_n;
  assign mem_go    = accept & ~fault;

  // Decode the request: fault detection or forced alignment.
  always_comb begin
    req_sz = size_e'(req_size);
    fault  = 1'b0;
    sz_n   = req_sz;
    off_n  = req_addr[1:0];
`ifdef BRAM_BRIDGE_ACCESS_FAULT_EN
    fault = ((req_sz == SZ_HALF) && req_addr[0]) ||
            ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
            (req_sz == SZ_RSVD) ||
            (req_addr[31:AW] != '0);
`else
    case (req_sz)
      SZ_BYTE: off_n = req_addr[1:0];
      SZ_HALF: off_n = {req_addr[1], 1'b0};
      default: begin
        sz_n  = SZ_WORD;
        off_n = 2'b00;
      end
    endcase
`endif
  end

`ifndef BRAM_BRIDGE_ACCESS_FAULT_EN
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];
`endif

  // RAM port is driven straight from the request during the accept cycle.
  always_comb begin
    mem_en    = mem_go;
    mem_addr  = req_addr[AW-1:0];
    mem_we    = 4'b0000;
    mem_wdata = req_wdata;
    case (sz_n)
      SZ_BYTE: begin
        mem_wdata = {4{req_wdata[7:0]}};
        if (mem_go && req_we) mem_we = 4'b0001 << off_n;
      end
      SZ_HALF: begin
        mem_wdata = {2{req_wdata[15:0]}};
        if (mem_go && req_we) mem_we = 4'b0011 << {off_n[1], 1'b0};
      end
      default: begin
        mem_wdata = req_wdata;
        if (mem_go && req_we) mem_we = 4'hF;
      end
    endcase
  end

  bram_load_align u_load_align (
    .rdata_i   (mem_rdata),
    .offset_i  (off_q),
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .result_o  (align_res)
  );

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (fault) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_we) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = StRdata;
            off_d   = off_n;
            size_d  = sz_n;
            uns_d   = req_unsigned;
          end
        end
      end
      StRdata: begin
        rsp_rdata_d = align_res;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bram_bus_bridge.sv
// Directed bench for bram_bus_bridge: vector table of transactions against a
// behavioural registered-read BRAM, plus stall and async-reset sequences.
module tb_bram_bus_bridge;

  localparam int AW = 14;
`ifdef BRAM_BRIDGE_ACCESS_FAULT_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;

  always #5 clk = ~clk;

  bram_bus_bridge #(.AW(AW), .DW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Registered-read, read-first block RAM.
  logic [31:0] ram [0:(1 << (AW - 2)) - 1];
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr[AW-1:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= ram[mem_addr[AW-1:2]];
    end
  end

  always @(posedge clk) if (mem_en === 1'b1) en_cnt <= en_cnt + 1;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_en;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                              input logic [31:0] exp);
    vec_t v;
    v.we = 1'b0; v.size = sz; v.uns = uns; v.addr = a; v.wdata = 32'h0;
    v.exp_en = 1'b1; v.exp_we = 4'h0; v.exp_wdata = 32'h0; v.exp_rdata = exp;
    v.exp_err = 1'b0; v.exp_lat = 2;
    return v;
  endfunction

  function automatic vec_t st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ewe, input logic [31:0] ewd);
    vec_t v;
    v.we = 1'b1; v.size = sz; v.uns = 1'b0; v.addr = a; v.wdata = wd;
    v.exp_en = 1'b1; v.exp_we = ewe; v.exp_wdata = ewd; v.exp_rdata = 32'h0;
    v.exp_err = 1'b0; v.exp_lat = 1;
    return v;
  endfunction

  function automatic vec_t flt(input logic we, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd);
    vec_t v;
    v.we = we; v.size = sz; v.uns = 1'b0; v.addr = a; v.wdata = wd;
    v.exp_en = 1'b0; v.exp_we = 4'h0; v.exp_wdata = 32'h0; v.exp_rdata = 32'h0;
    v.exp_err = 1'b1; v.exp_lat = 1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic txn(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    #1;
    chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'(v.exp_en));
    chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.exp_we));
    if (v.exp_en) chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.addr[AW-1:0]));
    if (v.exp_we != 4'h0) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk($sformatf("v%0d rsp_valid after hs", idx), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int en0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

    vecs.push_back(st(2'd2, 32'h1000, 32'h8081_82F3, 4'hF, 32'h8081_82F3));
    vecs.push_back(st(2'd2, 32'h0000, 32'h55AA_55AA, 4'hF, 32'h55AA_55AA));
    vecs.push_back(st(2'd2, 32'h0004, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D));
    vecs.push_back(st(2'd2, 32'h2000, 32'h1122_3344, 4'hF, 32'h1122_3344));
    vecs.push_back(ld(2'd0, 1'b0, 32'h1003, 32'hFFFF_FF80));
    vecs.push_back(ld(2'd0, 1'b1, 32'h1003, 32'h0000_0080));
    vecs.push_back(ld(2'd0, 1'b0, 32'h1000, 32'hFFFF_FFF3));
    vecs.push_back(ld(2'd1, 1'b0, 32'h1002, 32'hFFFF_8081));
    vecs.push_back(ld(2'd1, 1'b1, 32'h1000, 32'h0000_82F3));
    vecs.push_back(ld(2'd2, 1'b0, 32'h1000, 32'h8081_82F3));
    vecs.push_back(st(2'd1, 32'h2002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF));
    vecs.push_back(ld(2'd2, 1'b0, 32'h2000, 32'hBEEF_3344));
    vecs.push_back(st(2'd0, 32'h2001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5));
    vecs.push_back(ld(2'd2, 1'b0, 32'h2000, 32'hBEEF_A544));
    vecs.push_back(ld(2'd0, 1'b0, 32'h2003, 32'hFFFF_FFBE));
    vecs.push_back(FAULT ? flt(1'b0, 2'd2, 32'h0006, 32'h0)
                         : ld(2'd2, 1'b0, 32'h0006, 32'hCAFE_F00D));
    vecs.push_back(FAULT ? flt(1'b0, 2'd1, 32'h1001, 32'h0)
                         : ld(2'd1, 1'b1, 32'h1001, 32'h0000_82F3));
    vecs.push_back(FAULT ? flt(1'b0, 2'd3, 32'h1001, 32'h0)
                         : ld(2'd3, 1'b0, 32'h1001, 32'h8081_82F3));
    vecs.push_back(FAULT ? flt(1'b1, 2'd2, 32'h0001_0000, 32'hDEAD_BEEF)
                         : st(2'd2, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF));
    vecs.push_back(ld(2'd2, 1'b0, 32'h0000, FAULT ? 32'h55AA_55AA : 32'hDEAD_BEEF));
    vecs.push_back(FAULT ? flt(1'b1, 2'd1, 32'h2001, 32'h0000_CAFE)
                         : st(2'd1, 32'h2001, 32'h0000_CAFE, 4'b0011, 32'hCAFE_CAFE));
    vecs.push_back(ld(2'd2, 1'b0, 32'h2000, FAULT ? 32'hBEEF_A544 : 32'hBEEF_CAFE));

    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) txn(vecs[i], i);

    // Back-pressure: response must hold while rsp_ready is low.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h1003;
    @(posedge clk); #1;
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h1000; req_wdata = 32'h0;
    en0 = en_cnt;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d rsp_rdata", c), rsp_rdata, 32'hFFFF_FF80);
      chk($sformatf("stall%0d req_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("stall%0d mem_en", c), 32'(mem_en), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall hs rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stall hs req_ready", 32'(req_ready), 32'd1);
    chk("stall no extra ram cycles", 32'(en_cnt), 32'(en0));
    @(posedge clk); #1;
    chk("stall idle rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stall ld word 0x1000", ram[12'h400], 32'h8081_82F3);

    // Async reset while a store response is pending.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h3000; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst pre rsp_valid", 32'(rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1000;
    #1;
    chk("rst async rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst async req_ready", 32'(req_ready), 32'd1);
    chk("rst mem_en held off", 32'(mem_en), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    txn(ld(2'd2, 1'b0, 32'h3000, 32'h0000_0077), 100);
    txn(ld(2'd0, 1'b0, 32'h1003, 32'hFFFF_FF80), 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_bus_bridge.md
Name: bram_bus_bridge

Overview:
- Single-outstanding request/response slave that converts core load/store transactions into cycles on the on-chip block RAM port.
- Drives the RAM's en, 4-bit byte write enable, byte address and write data.
- Captures the RAM's registered read data, then aligns and sign/zero-extends it for the requester.
- Sits directly upstream of the instruction/data BRAM, between the core LSU/fetch bus and the memory macro.

Parameters:
- AW, 14, BRAM byte-address width (16 KB window).
- DW, 32, data width; only 32 is supported, elaboration error otherwise.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept request
- req_addr  in  32  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  zero-extend loads when 1
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  load result (0 for stores)
- rsp_err  out  1  access fault (see Optional Feature)
- mem_en  out  1  BRAM enable
- mem_we  out  4  BRAM byte write enables
- mem_addr  out  AW  BRAM byte address
- mem_wdata  out  32  BRAM write data
- mem_rdata  in  32  BRAM registered read data

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. Reset forces IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0 and clears all captured request fields.
- FSM states IDLE, RDATA, RESP.
  - req_ready = (state==IDLE).
  - Accept = req_valid & req_ready.
- Memory port outputs are combinational from req_* during the accept cycle only:
  - mem_en = accept; mem_addr = req_addr[AW-1:0].
  - Outside the accept cycle mem_en=0 and mem_we=0.
- Byte enables and store data:
  - byte: mem_we = 4'b0001<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_we = 4'b0011<<{addr[1],1'b0}; mem_wdata = {2{wdata[15:0]}}.
  - word: mem_we = 4'hF; mem_wdata = wdata.
  - For loads, mem_we = 0.
- Accepted load: IDLE→RDATA. Captured addr[1:0], size and unsigned are registered.
- RDATA (one cycle): mem_rdata is valid. Extract the lane, extend, register into rsp_rdata; assert rsp_valid; go to RESP.
- Accepted store: IDLE→RESP directly, with rsp_rdata=0 and rsp_valid=1.
- Load latency: rsp_valid rises 2 cycles after the accept edge. Store latency: 1 cycle.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready. Then go to IDLE and clear rsp_valid. The next request is accepted on the following cycle, never the same cycle.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Sign bit = MSB of the extracted field unless req_unsigned=1.
  - Word passes through unchanged.
- Reset mid-operation: a BRAM write already clocked stays committed. A pending response is discarded. No RAM cycle is issued while rst_n=0.
- Never more than one outstanding transaction. req_* is ignored outside IDLE.

Optional Feature:
- Macro BRAM_BRIDGE_ACCESS_FAULT_EN.
- Defined: a fault is any of:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size==3;
  - req_addr[31:AW]!=0.
  
  On a fault, mem_en stays 0 and the FSM goes IDLE→RESP with rsp_err=1 and rsp_rdata=0 (latency 1, loads and stores alike).
- Undefined: rsp_err is tied 0.
  - Low address bits are forced aligned: half ignores addr[0]; word ignores addr[1:0].
  - size 3 is treated as word.
  - Upper address bits alias into the window.

Decomposition:
- Package bram_bridge_pkg holds:
  - the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - the FSM state enum;
  - the NOP constant 32'h00000013 shared with memory models.
- One combinational sub-module, bram_load_align: inputs rdata, offset, size, unsigned; output extended result. It is reused by the fetch path.

Test Plan:
- Preload word 0x1000 = 0x8081_82F3. Load byte at 0x1003, signed → rsp_rdata=0xFFFF_FF80, rsp_valid exactly 2 cycles after accept. Same access unsigned → 0x0000_0080.
- Store half 0xBEEF at 0x2002 → mem_we=4'b1100, mem_wdata=0xBEEF_BEEF. A following word load at 0x2000 returns 0xBEEF_xxxx with the low half unchanged.
- Hold rsp_ready=0 for 5 cycles after a load → rsp_valid and rsp_rdata stable, req_ready=0, mem_en never asserted. Release → exactly one handshake, then IDLE.
- Assert rst_n=0 asynchronously while in RESP → rsp_valid drops immediately without a clock. After release req_ready=1 and the next load completes normally.
- With BRAM_BRIDGE_ACCESS_FAULT_EN: word load at 0x0000_0006 → rsp_err=1, rsp_rdata=0, mem_en=0, latency 1. Store to 0x0001_0000 (AW=14) → rsp_err=1 and memory unchanged.
- Without the macro: word load at 0x0000_0006 → reads word 0x4, rsp_err=0.
